pipe_addsub: RTL and testbench
==============================

Name: pipe_addsub

Overview:
- Parametrised, pipelined add/subtract unit: successor to the team's fixed 4-bit registered adder.
- Carry chain is split into STAGES equal slices, one register stage per slice, so WIDTH scales without closing a long carry path in one cycle.
- Adds per-transaction add/sub, signed/unsigned and saturation modes, plus carry/overflow/zero flags.
- Uses a valid/ready handshake on both sides, with global En freeze; sits between operand sources and the datapath writeback.

Parameters:
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
- STAGES, 2, number of carry slices = pipeline latency in cycles; 1..WIDTH.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- En  input  1  global enable; 0 freezes all pipeline state
- In_valid  input  1  operand transaction present
- In_ready  output  1  unit accepts transaction this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Sub  input  1  1 = A-B, 0 = A+B
- Signed  input  1  1 = two's-complement overflow/saturation rules
- Sat  input  1  1 = clamp result on overflow
- Out_valid  output  1  result present
- Out_ready  input  1  downstream accepts result
- Sum  output  WIDTH  result (saturated if Sat && Overflow)
- Carry  output  1  raw carry-out of WIDTH-bit add (sub: 1 = no borrow)
- Overflow  output  1  range overflow per Signed/Sub
- Zero  output  1  Sum == 0

Behaviour:
- Reset (Rst_n=0, async): all stage valid bits, Out_valid, Sum, Carry, Overflow and Zero are 0. In-flight transactions are discarded. Release is sampled on the next Clk edge.
- Advance: adv = En && (!Out_valid || Out_ready). When adv=1, every stage shifts by one. When adv=0, all stage registers hold.
- In_ready = adv. This is a combinational path from Out_ready and En; it is documented, and no skid buffer is used.
- Accept: a transaction is accepted when In_valid && In_ready. A non-accepted cycle with adv=1 injects a bubble (valid=0).
- Latency: exactly STAGES advancing cycles from accept to Out_valid. Throughput is 1 per cycle while Out_ready=1 and En=1.
- Operand prep (stage 0 input): B' = Sub ? ~B : B, cin = Sub.
- Slice k (k = 0..STAGES-1) adds bits [k*W/S +: W/S] of A and B' with the carry registered from slice k-1.
  - Upper operand slices and lower result slices are delay-registered alongside.
  - Sub, Signed and Sat travel with the data, along with the sign bits of A and B' (needed for the signed overflow rule).
- Final stage: flags and saturation are computed combinationally before the output register.
  - Carry = carry-out of slice STAGES-1.
  - Unsigned overflow: add gives Overflow = Carry; sub gives Overflow = !Carry (borrow).
  - Signed overflow: Overflow = (A[msb] == B'[msb]) && (raw[msb] != A[msb]).
  - Saturation (Sat && Overflow):
    - unsigned add → all ones; unsigned sub → 0.
    - signed with A[msb]=0 → 0111…1; signed with A[msb]=1 → 1000…0.
  - Otherwise Sum = raw.
  - Zero is evaluated on the final (post-saturation) Sum.
- Output hold: while Out_valid && !Out_ready, Sum and all flags are stable.
- Output register: Sum/flags update only when adv=1 and the last stage holds valid data. Out_valid follows the last-stage valid bit.
- Mode changes take effect per transaction; there is no interaction between in-flight transactions.
- En=0 mid-stream: the pipeline freezes with no loss or duplication. Out_valid remains asserted, but the result is not consumed until En=1.
- STAGES=1 degenerates to a single registered adder with handshake.

Decomposition:
- Shared package addsub_pkg: mode-field struct/constants (SUB, SIGNED, SAT bit positions) and the saturation constant functions (max/min signed and unsigned for a given WIDTH).
- Sub-module addsub_slice: one W/S-bit slice adder with registered sum and carry-out, operand delay and valid/hold enable. It is generated STAGES times.

Test Plan:
- Unsigned add, WIDTH=16, STAGES=2: A=0x1234, B=0x0FFF, Sub=0 → after 2 cycles Sum=0x2233, Carry=0, Overflow=0, Zero=0.
- Unsigned sub with saturation: A=0x0005, B=0x0009, Sub=1, Sat=1 → Sum=0x0000, Carry=0, Overflow=1, Zero=1; same with Sat=0 → Sum=0xFFFC, Overflow=1, Zero=0.
- Signed overflow: A=0x7FFF, B=0x0001, Signed=1, Sat=1 → Sum=0x7FFF, Overflow=1; A=0x8000, B=0x0001, Sub=1, Signed=1, Sat=1 → Sum=0x8000, Overflow=1.
- Back-to-back stream: 8 accepted transactions on consecutive cycles with Out_ready=1 → 8 results on consecutive cycles in order, latency 2. Carry-crossing slice case A=0x00FF, B=0x0001 → 0x0100.
- Backpressure/En: hold Out_ready=0 for 3 cycles mid-stream, then drop En for 2 cycles → In_ready=0 throughout, Sum/flags stable, no lost or duplicated results afterwards.
- Reset mid-operation: assert Rst_n=0 asynchronously with 2 transactions in flight → Out_valid=0 and Sum=0 immediately; no stale result emerges after release.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: mode field layout
// and the saturation constants for a given operand width (up to 64 bits).
package addsub_pkg;

  localparam int MODE_SUB    = 0;
  localparam int MODE_SIGNED = 1;
  localparam int MODE_SAT    = 2;
  localparam int MODE_BITS   = 3;

  // Field order matches the MODE_* bit positions (sub is bit 0).
  typedef struct packed {
    logic sat;
    logic signd;
    logic sub;
  } mode_t;

  function automatic logic [63:0] umax_of(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] umin_of(input int w);
    if (w < 0) return '1;
    return '0;
  endfunction

  function automatic logic [63:0] smax_of(input int w);
    return umax_of(w) >> 1;
  endfunction

  function automatic logic [63:0] smin_of(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry slice of the pipeline: adds the lowest SW bits of the remaining
// operands, registers the slice sum into the top of the result vector and the
// carry-out, and shifts the untouched operand slices down for the next stage.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] res,
  input  logic             cin,
  input  mode_t            mode,
  output logic             valid_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] res_q,
  output logic             cout_q,
  output mode_t            mode_q
);

  logic [SW-1:0] sum;
  logic          cout;
  logic          unused_res;

  assign {cout, sum} = {1'b0, a[SW-1:0]} + {1'b0, b[SW-1:0]} + {{SW{1'b0}}, cin};

  // The low result bits are still empty filler at this point; they shift out.
  assign unused_res = ^res[SW-1:0];

  // Stage register: shifts the whole slice payload forward when the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      mode_q  <= '0;
    end else if (en) begin
      valid_q <= valid;
      a_q     <= {{SW{1'b0}}, a[WIDTH-1:SW]};
      b_q     <= {{SW{1'b0}}, b[WIDTH-1:SW]};
      res_q   <= {sum, res[WIDTH-1:SW]};
      cout_q  <= cout;
      mode_q  <= mode;
    end
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract with signed/unsigned overflow, saturation and flags.
// STAGES-1 registered carry slices feed a final slice whose register is the
// output register, so latency is exactly STAGES advancing cycles.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  input  logic             Signed,
  input  logic             Sat,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  localparam logic [63:0] UMAX_W = umax_of(WIDTH);
  localparam logic [63:0] UMIN_W = umin_of(WIDTH);
  localparam logic [63:0] SMAX_W = smax_of(WIDTH);
  localparam logic [63:0] SMIN_W = smin_of(WIDTH);
  localparam logic [WIDTH-1:0] UMAX = UMAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] UMIN = UMIN_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMAX = SMAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN = SMIN_W[WIDTH-1:0];

  logic adv;

  logic             st_v   [STAGES];
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_res [STAGES];
  logic             st_c   [STAGES];
  mode_t            st_m   [STAGES];

  logic [MODE_BITS-1:0] mode_in;

  logic [SW-1:0]    fin_sum;
  logic             fin_c;
  logic [WIDTH-1:0] raw;
  logic             sa;
  logic             sb;
  logic             ovf;
  logic [WIDTH-1:0] sum_n;

  // In_ready is combinational from Out_ready and En; there is no skid buffer.
  assign adv      = En && (!Out_valid || Out_ready);
  assign In_ready = adv;

  assign mode_in[MODE_SUB]    = Sub;
  assign mode_in[MODE_SIGNED] = Signed;
  assign mode_in[MODE_SAT]    = Sat;

  // Operand prep: subtraction is A + ~B + 1.
  assign st_v[0]   = In_valid;
  assign st_a[0]   = A;
  assign st_b[0]   = Sub ? ~B : B;
  assign st_res[0] = '0;
  assign st_c[0]   = Sub;
  assign st_m[0]   = mode_t'(mode_in);

  for (genvar k = 0; k < STAGES - 1; k++) begin : g_slice
    addsub_slice #(
      .WIDTH (WIDTH),
      .SW    (SW)
    ) u_slice (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .en      (adv),
      .valid   (st_v[k]),
      .a       (st_a[k]),
      .b       (st_b[k]),
      .res     (st_res[k]),
      .cin     (st_c[k]),
      .mode    (st_m[k]),
      .valid_q (st_v[k+1]),
      .a_q     (st_a[k+1]),
      .b_q     (st_b[k+1]),
      .res_q   (st_res[k+1]),
      .cout_q  (st_c[k+1]),
      .mode_q  (st_m[k+1])
    );
  end

  // Final slice: the top operand slice now sits in the low SW bits.
  assign {fin_c, fin_sum} = {1'b0, st_a[L][SW-1:0]} + {1'b0, st_b[L][SW-1:0]}
                          + {{SW{1'b0}}, st_c[L]};
  assign sa = st_a[L][SW-1];
  assign sb = st_b[L][SW-1];

  if (STAGES == 1) begin : g_raw_single
    logic unused_bits;
    assign raw         = fin_sum;
    assign unused_bits = ^st_res[0];
  end else begin : g_raw_multi
    // Upper operand bits are zero fill and low result bits are empty fill here.
    logic unused_bits;
    assign raw         = {fin_sum, st_res[L][WIDTH-1:SW]};
    assign unused_bits = ^{st_a[L][WIDTH-1:SW], st_b[L][WIDTH-1:SW], st_res[L][SW-1:0]};
  end

  // Overflow detection and saturation ahead of the output register.
  always_comb begin
    ovf   = 1'b0;
    sum_n = raw;
    if (st_m[L].signd)
      ovf = (sa == sb) && (raw[WIDTH-1] != sa);
    else if (st_m[L].sub)
      ovf = !fin_c;
    else
      ovf = fin_c;
    if (st_m[L].sat && ovf) begin
      if (st_m[L].signd)
        sum_n = sa ? SMIN : SMAX;
      else
        sum_n = st_m[L].sub ? UMIN : UMAX;
    end
  end

  // Output register: loads only on an advancing cycle carrying valid data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_valid <= 1'b0;
      Sum       <= '0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      Zero      <= 1'b0;
    end else if (adv) begin
      Out_valid <= st_v[L];
      if (st_v[L]) begin
        Sum      <= sum_n;
        Carry    <= fin_c;
        Overflow <= ovf;
        Zero     <= (sum_n == '0);
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=16, STAGES=2) with a
// plain-arithmetic reference model and an in-order expectation queue.
module tb_pipe_addsub;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              En;
  logic              In_valid;
  logic              In_ready;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              Sub;
  logic              Signed;
  logic              Sat;
  logic              Out_valid;
  logic              Out_ready;
  logic [WIDTH-1:0]  Sum;
  logic              Carry;
  logic              Overflow;
  logic              Zero;

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        sgn;
    logic        sat;
    res_t        exp;
  } vec_t;

  res_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_acc = 0;
  int   errors = 0;
  int   checks = 0;

  pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .En        (En),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .A         (A),
    .B         (B),
    .Sub       (Sub),
    .Signed    (Signed),
    .Sat       (Sat),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Sum       (Sum),
    .Carry     (Carry),
    .Overflow  (Overflow),
    .Zero      (Zero)
  );

  always #5 Clk = ~Clk;

  // Reference: true integer results and range checks.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic sgn, input logic sat);
    int ua, ub, sa, sb, t, ts;
    logic [15:0] r;
    logic c, o;
    ua = {16'd0, a};
    ub = {16'd0, b};
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    if (!sub) begin
      t = ua + ub;
      c = (t > 65535);
    end else begin
      t = ua - ub;
      c = (ua >= ub);
    end
    r = t[15:0];
    if (sgn) begin
      ts = sub ? sa - sb : sa + sb;
      o  = (ts > 32767) || (ts < -32768);
      if (sat && o) r = (ts > 0) ? 16'h7FFF : 16'h8000;
    end else begin
      o = sub ? !c : c;
      if (sat && o) r = sub ? 16'h0000 : 16'hFFFF;
    end
    return '{sum: r, c: c, o: o, z: (r == 16'd0)};
  endfunction

  // One clock: drive at the falling edge, then report what the next rising
  // edge will do (accept / consume) and the outputs currently presented.
  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic sgn, input logic sat,
                       input logic ordy, input logic en,
                       output logic took, output res_t got, output logic ov,
                       output logic rdy, output int idx);
    @(negedge Clk);
    In_valid = v; A = a; B = b; Sub = sub; Signed = sgn; Sat = sat;
    Out_ready = ordy; En = en;
    #1;
    rdy  = In_ready;
    ov   = Out_valid;
    got  = '{sum: Sum, c: Carry, o: Overflow, z: Zero};
    took = Out_valid && Out_ready && En;
    idx  = cyc;
    if (v && In_ready) begin
      exp_q.push_back(model(a, b, sub, sgn, sat));
      acc_q.push_back(cyc);
      n_acc++;
    end
    cyc++;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; En = 1'b1; In_valid = 1'b0; A = '0; B = '0;
    Sub = 1'b0; Signed = 1'b0; Sat = 1'b0; Out_ready = 1'b1;
    #3;
    checks++;
    if ({Out_valid, Sum, Carry, Overflow, Zero} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got %h want 00000", {Out_valid, Sum, Carry, Overflow, Zero});
    end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t vecs[12];
    logic took, ov, rdy, found;
    res_t got, e;
    int idx, acc;
    vecs[0]  = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{16'h0005, 16'h0009, 1'b1, 1'b0, 1'b1, '{16'h0000, 1'b0, 1'b1, 1'b1}};
    vecs[2]  = '{16'h0005, 16'h0009, 1'b1, 1'b0, 1'b0, '{16'hFFFC, 1'b0, 1'b1, 1'b0}};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, '{16'h7FFF, 1'b0, 1'b1, 1'b0}};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, '{16'h8000, 1'b1, 1'b1, 1'b0}};
    vecs[5]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, '{16'hFFFF, 1'b1, 1'b1, 1'b0}};
    vecs[7]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1}};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, '{16'hFFFE, 1'b1, 1'b0, 1'b0}};
    vecs[9]  = '{16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}};
    vecs[10] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
    vecs[11] = '{16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b0, '{16'h0001, 1'b1, 1'b1, 1'b0}};
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sgn, vecs[i].sat,
            1'b1, 1'b1, took, got, ov, rdy, idx);
      found = 1'b0;
      for (int j = 0; j < 10 && !found; j++) begin
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, took, got, ov, rdy, idx);
        if (took) begin
          found = 1'b1;
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          checks++;
          if (idx - acc !== STAGES) begin
            errors++;
            $display("FAIL directed_latency[%0d]: got %0d want %0d", i, idx - acc, STAGES);
          end
          checks++;
          if (got !== vecs[i].exp) begin
            errors++;
            $display("FAIL directed_result[%0d]: got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                     i, got.sum, got.c, got.o, got.z,
                     vecs[i].exp.sum, vecs[i].exp.c, vecs[i].exp.o, vecs[i].exp.z);
          end
        end
      end
      if (!found) begin
        checks++; errors++;
        $display("FAIL directed_timeout[%0d]: got no result want one", i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic took, ov, rdy;
    res_t got, e;
    int idx, acc, n_cons;
    n_cons = 0;
    for (int i = 0; i < 40; i++) begin
      if (i >= 8 && exp_q.size() == 0) break;
      cycle(i < 8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'b1, 1'b1, took, got, ov, rdy, idx);
      if (took) begin
        n_cons++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b_unexpected: got sum=%h want no result", got.sum);
        end else begin
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          checks++;
          if (got !== e || idx - acc !== STAGES) begin
            errors++;
            $display("FAIL b2b_result: got %h lat=%0d want %h lat=%0d", got, idx - acc, e, STAGES);
          end
        end
      end
    end
    checks++;
    if (n_cons !== 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 8", n_cons);
    end
  endtask

  task automatic test_backpressure();
    logic took, ov, rdy, ordy, en, p_ov, p_took;
    res_t got, e, p_got;
    int idx, n_cons, acc0;
    n_cons = 0; acc0 = n_acc; p_ov = 1'b0; p_took = 1'b0; p_got = '0;
    for (int i = 0; i < 60; i++) begin
      if (i >= 12 && exp_q.size() == 0) break;
      ordy = !(i >= 4 && i <= 6);
      en   = !(i == 7 || i == 8);
      cycle(i < 12, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ordy, en, took, got, ov, rdy, idx);
      if (i >= 4 && i <= 8) begin
        checks++;
        if (rdy !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready[%0d]: got %b want 0", i, rdy);
        end
      end
      if (p_ov && !p_took) begin
        checks++;
        if ({ov, got} !== {1'b1, p_got}) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", i, ov, got, p_got);
        end
      end
      if (took) begin
        n_cons++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_unexpected: got sum=%h want no result", got.sum);
        end else begin
          e = exp_q.pop_front();
          void'(acc_q.pop_front());
          if (got !== e) begin
            errors++;
            $display("FAIL bp_result: got %h want %h", got, e);
          end
        end
      end
      p_ov = ov; p_took = took; p_got = got;
    end
    checks++;
    if (n_cons !== n_acc - acc0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d consumed want %0d", n_cons, n_acc - acc0);
    end
  endtask

  task automatic test_random();
    logic took, ov, rdy, v, ordy, en, p_ov, p_took;
    res_t got, e, p_got;
    int idx;
    p_ov = 1'b0; p_took = 1'b0; p_got = '0;
    for (int i = 0; i < 400; i++) begin
      if (i >= 300 && exp_q.size() == 0) break;
      v    = (i < 300) ? 1'($urandom) : 1'b0;
      ordy = (i < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
      en   = (i < 300) ? ($urandom_range(0, 9) != 0) : 1'b1;
      cycle(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ordy, en, took, got, ov, rdy, idx);
      if (p_ov && !p_took && ({ov, got} !== {1'b1, p_got})) begin
        checks++; errors++;
        $display("FAIL rand_hold[%0d]: got v=%b %h want v=1 %h", i, ov, got, p_got);
      end
      if (took) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected: got sum=%h want no result", got.sum);
        end else begin
          e = exp_q.pop_front();
          void'(acc_q.pop_front());
          if (got !== e) begin
            errors++;
            $display("FAIL rand_result: got %h want %h", got, e);
          end
        end
      end
      p_ov = ov; p_took = took; p_got = got;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic took, ov, rdy;
    res_t got;
    int idx, seen;
    cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, took, got, ov, rdy, idx);
    cycle(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, took, got, ov, rdy, idx);
    @(posedge Clk);
    #2;
    checks++;
    if (Out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_inflight: got Out_valid=%b want 1", Out_valid);
    end
    Rst_n = 1'b0;
    In_valid = 1'b0;
    #1;
    checks++;
    if ({Out_valid, Sum, Carry, Overflow, Zero} !== 20'h0) begin
      errors++;
      $display("FAIL rstmid_async: got %h want 00000", {Out_valid, Sum, Carry, Overflow, Zero});
    end
    exp_q.delete();
    acc_q.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, took, got, ov, rdy, idx);
      if (ov) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rstmid_stale: got %0d valid cycles want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
